// File: rtl/axi4_lite_read_master_engine.sv
// AXI4-Lite read master engine.
// Accepts local read requests, issues in-window ones on AR and completes out-of-window
// ones locally with DECERR. Up to MaxOutstanding requests may be accepted but not yet
// answered; responses always leave in request-acceptance order through a single output
// register. MaxOutstanding = 1 gives blocking reads.
//
// Ports:
//   aclk_i, areset_i          clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   request handshake, req_addr_i / req_prot_i payload
//   rsp_valid_o/rsp_ready_i   response handshake, rsp_data_o / rsp_resp_o payload
//   araddr_o, arprot_o, arvalid_o, arready_i   AR channel
//   rdata_i, rresp_i, rvalid_i, rready_o       R channel
//   outstanding_o             order-FIFO occupancy
module axi4_lite_read_master_engine #(
  parameter int unsigned             AddressWidth   = 32,
  parameter int unsigned             DataWidth      = 32,
  parameter int unsigned             MaxOutstanding = 4,
  parameter logic [AddressWidth-1:0] MinAddress     = '0,
  parameter logic [AddressWidth-1:0] MaxAddress     = '1,
  localparam int unsigned            CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                    aclk_i,
  input  logic                    areset_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddressWidth-1:0] req_addr_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DataWidth-1:0]    rsp_data_o,
  output logic [1:0]              rsp_resp_o,
  output logic [AddressWidth-1:0] araddr_o,
  output logic [2:0]              arprot_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [DataWidth-1:0]    rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  output logic [CntWidth-1:0]     outstanding_o
);

  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxOutstanding);

  // Order FIFO: 0 = bus read, 1 = local DECERR.
  logic [MaxOutstanding-1:0] fifo_q, fifo_d;
  logic [PtrWidth-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]       count_q, count_d;

  logic                    ar_valid_q, ar_valid_d;
  logic [AddressWidth-1:0] ar_addr_q, ar_addr_d;
  logic [2:0]              ar_prot_q, ar_prot_d;

  logic                 rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]           rsp_resp_q, rsp_resp_d;

  logic ge_min, le_max, in_range;
  logic fifo_full, fifo_empty, head;
  logic out_free, push, pop, load_local, load_bus;

  // Bounds at the extremes of the address space are trivially met; skipping the compare
  // avoids constant-result comparisons.
  if (MinAddress == '0) begin : g_no_min
    assign ge_min = 1'b1;
  end else begin : g_min
    assign ge_min = (req_addr_i >= MinAddress);
  end

  if (MaxAddress == '1) begin : g_no_max
    assign le_max = 1'b1;
  end else begin : g_max
    assign le_max = (req_addr_i <= MaxAddress);
  end

  assign in_range = ge_min && le_max;

  // Full comes from the registered count, so a pop never frees a slot in the same cycle.
  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  assign req_ready_o = !areset_i && !fifo_full && !(ar_valid_q && !arready_i);
  assign push        = req_valid_i && req_ready_o;

  assign out_free   = !rsp_valid_q || rsp_ready_i;
  assign rready_o   = !fifo_empty && !head && out_free;
  assign load_bus   = rvalid_i && rready_o;
  assign load_local = !fifo_empty && head && out_free;
  assign pop        = load_bus || load_local;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = !in_range;
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntWidth'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntWidth'(1);
    end
  end

  // A push is only possible when AR is idle or handshaking, so reloading never drops an AR.
  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    ar_prot_d  = ar_prot_q;
    if (push && in_range) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = req_addr_i;
      ar_prot_d  = req_prot_i;
    end else if (ar_valid_q && arready_i) begin
      ar_valid_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;
    if (load_local) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = '0;
      rsp_resp_d  = 2'b11;
    end else if (load_bus) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rdata_i;
      rsp_resp_d  = rresp_i;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      ar_prot_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= '0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ar_valid_q  <= ar_valid_d;
      ar_addr_q   <= ar_addr_d;
      ar_prot_q   <= ar_prot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign arvalid_o     = ar_valid_q;
  assign araddr_o      = ar_addr_q;
  assign arprot_o      = ar_prot_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_resp_o    = rsp_resp_q;
  assign outstanding_o = count_q;

endmodule

// File: tb/tb_axi4_lite_read_master_engine.sv
// Directed bench: instance A (4 outstanding, full window) covers single read, outstanding
// limit, backpressure and reset mid-flight; instance B (blocking, window 0x100..0x1FF)
// covers range errors and blocking mode.
module tb_axi4_lite_read_master_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Instance A
  logic        a_req_valid = 1'b0, a_req_ready;
  logic [31:0] a_req_addr = '0;
  logic [2:0]  a_req_prot = '0;
  logic        a_rsp_valid, a_rsp_ready = 1'b0;
  logic [31:0] a_rsp_data;
  logic [1:0]  a_rsp_resp;
  logic [31:0] a_araddr;
  logic [2:0]  a_arprot;
  logic        a_arvalid, a_arready = 1'b0;
  logic [31:0] a_rdata = '0;
  logic [1:0]  a_rresp = '0;
  logic        a_rvalid = 1'b0, a_rready;
  logic [2:0]  a_outstanding;

  // Instance B
  logic        b_req_valid = 1'b0, b_req_ready;
  logic [31:0] b_req_addr = '0;
  logic [2:0]  b_req_prot = '0;
  logic        b_rsp_valid, b_rsp_ready = 1'b0;
  logic [31:0] b_rsp_data;
  logic [1:0]  b_rsp_resp;
  logic [31:0] b_araddr;
  logic [2:0]  b_arprot;
  logic        b_arvalid, b_arready = 1'b0;
  logic [31:0] b_rdata = '0;
  logic [1:0]  b_rresp = '0;
  logic        b_rvalid = 1'b0, b_rready;
  logic [0:0]  b_outstanding;

  int a_ar_cnt = 0;
  int b_ar_cnt = 0;
  always @(posedge clk) if (a_arvalid && a_arready) a_ar_cnt <= a_ar_cnt + 1;
  always @(posedge clk) if (b_arvalid && b_arready) b_ar_cnt <= b_ar_cnt + 1;

  axi4_lite_read_master_engine #(
    .AddressWidth(32), .DataWidth(32), .MaxOutstanding(4)
  ) u_dut_a (
    .aclk_i(clk), .areset_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
    .req_addr_i(a_req_addr), .req_prot_i(a_req_prot),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_data_o(a_rsp_data), .rsp_resp_o(a_rsp_resp),
    .araddr_o(a_araddr), .arprot_o(a_arprot), .arvalid_o(a_arvalid), .arready_i(a_arready),
    .rdata_i(a_rdata), .rresp_i(a_rresp), .rvalid_i(a_rvalid), .rready_o(a_rready),
    .outstanding_o(a_outstanding)
  );

  axi4_lite_read_master_engine #(
    .AddressWidth(32), .DataWidth(32), .MaxOutstanding(1),
    .MinAddress(32'h0000_0100), .MaxAddress(32'h0000_01FF)
  ) u_dut_b (
    .aclk_i(clk), .areset_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .req_addr_i(b_req_addr), .req_prot_i(b_req_prot),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_data_o(b_rsp_data), .rsp_resp_o(b_rsp_resp),
    .araddr_o(b_araddr), .arprot_o(b_arprot), .arvalid_o(b_arvalid), .arready_i(b_arready),
    .rdata_i(b_rdata), .rresp_i(b_rresp), .rvalid_i(b_rvalid), .rready_o(b_rready),
    .outstanding_o(b_outstanding)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    // ---------------- reset values ----------------
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", a_req_ready, 0);
    chk("rst_arvalid", a_arvalid, 0);
    chk("rst_araddr", a_araddr, 0);
    chk("rst_rready", a_rready, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_data", a_rsp_data, 0);
    chk("rst_outstanding", a_outstanding, 0);
    chk("rst_b_req_ready", b_req_ready, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // ---------------- single read ----------------
    a_rsp_ready = 1'b1;
    a_req_valid = 1'b1; a_req_addr = 32'h10; a_req_prot = 3'b010;
    #1 chk("t1_req_ready", a_req_ready, 1);
    tick();
    a_req_valid = 1'b0;
    chk("t1_arvalid", a_arvalid, 1);
    chk("t1_araddr", a_araddr, 32'h10);
    chk("t1_arprot", a_arprot, 3'b010);
    chk("t1_outstanding", a_outstanding, 1);
    tick();
    chk("t1_arvalid_hold", a_arvalid, 1);
    chk("t1_araddr_hold", a_araddr, 32'h10);
    a_arready = 1'b1;
    tick();
    a_arready = 1'b0;
    chk("t1_arvalid_drop", a_arvalid, 0);
    a_rvalid = 1'b1; a_rdata = 32'hDEAD_BEEF; a_rresp = 2'b00;
    #1 chk("t1_rready", a_rready, 1);
    tick();
    a_rvalid = 1'b0;
    chk("t1_rsp_valid", a_rsp_valid, 1);
    chk("t1_rsp_data", a_rsp_data, 32'hDEAD_BEEF);
    chk("t1_rsp_resp", a_rsp_resp, 2'b00);
    chk("t1_outstanding_end", a_outstanding, 0);
    tick();
    chk("t1_rsp_consumed", a_rsp_valid, 0);

    // ---------------- outstanding limit ----------------
    a_arready = 1'b1;
    base = a_ar_cnt;
    for (int i = 0; i < 4; i++) begin
      a_req_valid = 1'b1; a_req_addr = 32'h100 + 32'(4 * i);
      #1 chk("t2_req_ready", a_req_ready, 1);
      tick();
    end
    a_req_addr = 32'h110;
    #1;
    chk("t2_full_ready", a_req_ready, 0);
    chk("t2_outstanding4", a_outstanding, 4);
    tick();
    chk("t2_ready_hold", a_req_ready, 0);
    chk("t2_ar_count4", a_ar_cnt - base, 4);
    chk("t2_arvalid_idle", a_arvalid, 0);
    a_rvalid = 1'b1; a_rdata = 32'hA0; a_rresp = 2'b00;
    #1 chk("t2_rready", a_rready, 1);
    tick();
    a_rdata = 32'hA1;
    #1;
    chk("t2_rsp0", a_rsp_data, 32'hA0);
    chk("t2_ready_after_pop", a_req_ready, 1);
    tick();
    a_req_valid = 1'b0; a_rdata = 32'hA2;
    chk("t2_rsp1", a_rsp_data, 32'hA1);
    chk("t2_outstanding3", a_outstanding, 3);
    tick();
    a_rdata = 32'hA3;
    chk("t2_rsp2", a_rsp_data, 32'hA2);
    tick();
    a_rdata = 32'hA4;
    chk("t2_rsp3", a_rsp_data, 32'hA3);
    tick();
    a_rvalid = 1'b0;
    chk("t2_rsp4", a_rsp_data, 32'hA4);
    chk("t2_rsp4_valid", a_rsp_valid, 1);
    chk("t2_outstanding0", a_outstanding, 0);
    chk("t2_ar_count5", a_ar_cnt - base, 5);
    tick();
    chk("t2_rsp_consumed", a_rsp_valid, 0);

    // ---------------- backpressure ----------------
    a_req_valid = 1'b1; a_req_addr = 32'h20;
    tick();
    a_req_addr = 32'h24;
    tick();
    a_req_valid = 1'b0;
    tick();
    chk("t3_outstanding2", a_outstanding, 2);
    a_rsp_ready = 1'b0; a_rvalid = 1'b1; a_rdata = 32'hB0; a_rresp = 2'b00;
    tick();
    a_rdata = 32'hB1;
    for (int i = 0; i < 10; i++) begin
      #1 chk("t3_rready_hold", a_rready, 0);
      tick();
    end
    chk("t3_rsp_held", a_rsp_data, 32'hB0);
    chk("t3_rsp_valid_held", a_rsp_valid, 1);
    chk("t3_outstanding1", a_outstanding, 1);
    a_rsp_ready = 1'b1;
    #1 chk("t3_rready_release", a_rready, 1);
    tick();
    a_rvalid = 1'b0;
    chk("t3_rsp_second", a_rsp_data, 32'hB1);
    chk("t3_rsp_second_valid", a_rsp_valid, 1);
    chk("t3_outstanding0", a_outstanding, 0);
    tick();
    chk("t3_rsp_consumed", a_rsp_valid, 0);

    // ---------------- range error (instance B) ----------------
    b_arready = 1'b1; b_rsp_ready = 1'b1;
    base = b_ar_cnt;
    b_req_valid = 1'b1; b_req_addr = 32'h100; b_req_prot = 3'b000;
    #1 chk("r_ready_first", b_req_ready, 1);
    tick();
    b_req_addr = 32'h200;
    #1;
    chk("r_blocked", b_req_ready, 0);
    chk("r_arvalid", b_arvalid, 1);
    chk("r_araddr", b_araddr, 32'h100);
    tick();
    b_rvalid = 1'b1; b_rdata = 32'hD0; b_rresp = 2'b00;
    tick();
    b_rvalid = 1'b0;
    chk("r_rsp0_valid", b_rsp_valid, 1);
    chk("r_rsp0_data", b_rsp_data, 32'hD0);
    chk("r_rsp0_resp", b_rsp_resp, 2'b00);
    #1 chk("r_ready_oor", b_req_ready, 1);
    tick();
    b_req_addr = 32'h1FF;
    chk("r_oor_no_rsp_yet", b_rsp_valid, 0);
    chk("r_oor_no_ar", b_arvalid, 0);
    chk("r_oor_outstanding", b_outstanding, 1);
    tick();
    chk("r_decerr_valid", b_rsp_valid, 1);
    chk("r_decerr_data", b_rsp_data, 0);
    chk("r_decerr_resp", b_rsp_resp, 2'b11);
    #1 chk("r_ready_max", b_req_ready, 1);
    tick();
    b_req_addr = 32'h0FF;
    chk("r_max_arvalid", b_arvalid, 1);
    chk("r_max_araddr", b_araddr, 32'h1FF);
    tick();
    b_rvalid = 1'b1; b_rdata = 32'hD1; b_rresp = 2'b00;
    tick();
    b_rvalid = 1'b0;
    chk("r_rsp2_data", b_rsp_data, 32'hD1);
    chk("r_rsp2_resp", b_rsp_resp, 2'b00);
    tick();
    b_req_valid = 1'b0;
    chk("r_below_no_ar", b_arvalid, 0);
    chk("r_below_outstanding", b_outstanding, 1);
    tick();
    chk("r_below_valid", b_rsp_valid, 1);
    chk("r_below_resp", b_rsp_resp, 2'b11);
    chk("r_ar_count", b_ar_cnt - base, 2);
    tick();

    // ---------------- blocking mode (instance B) ----------------
    base = b_ar_cnt;
    b_req_valid = 1'b1; b_req_addr = 32'h180;
    tick();
    b_req_addr = 32'h184;
    #1 chk("b_blocked", b_req_ready, 0);
    tick();
    chk("b_ar1_done", b_arvalid, 0);
    b_rvalid = 1'b1; b_rdata = 32'hE0; b_rresp = 2'b10;
    tick();
    b_rvalid = 1'b0;
    chk("b_rsp0_valid", b_rsp_valid, 1);
    chk("b_rsp0_resp", b_rsp_resp, 2'b10);
    chk("b_rsp0_data", b_rsp_data, 32'hE0);
    chk("b_no_second_ar", b_arvalid, 0);
    chk("b_ar_count1", b_ar_cnt - base, 1);
    tick();
    b_req_valid = 1'b0;
    chk("b_ar2_valid", b_arvalid, 1);
    chk("b_ar2_addr", b_araddr, 32'h184);
    tick();
    b_rvalid = 1'b1; b_rdata = 32'hE1; b_rresp = 2'b10;
    tick();
    b_rvalid = 1'b0;
    chk("b_rsp1_resp", b_rsp_resp, 2'b10);
    chk("b_rsp1_data", b_rsp_data, 32'hE1);
    chk("b_ar_count2", b_ar_cnt - base, 2);
    tick();

    // ---------------- reset mid-flight (instance A) ----------------
    a_arready = 1'b1;
    a_req_valid = 1'b1; a_req_addr = 32'h30;
    tick();
    a_req_addr = 32'h34;
    tick();
    a_req_addr = 32'h38;
    tick();
    a_req_valid = 1'b0; a_arready = 1'b0;
    #1;
    chk("t4_outstanding3", a_outstanding, 3);
    chk("t4_arvalid", a_arvalid, 1);
    rst = 1'b1;
    #1;
    chk("t4_rst_arvalid", a_arvalid, 0);
    chk("t4_rst_araddr", a_araddr, 0);
    chk("t4_rst_outstanding", a_outstanding, 0);
    chk("t4_rst_req_ready", a_req_ready, 0);
    chk("t4_rst_rready", a_rready, 0);
    chk("t4_rst_rsp_valid", a_rsp_valid, 0);
    tick();
    rst = 1'b0;
    #1 chk("t4_post_rready", a_rready, 0);
    a_req_valid = 1'b1; a_req_addr = 32'h40; a_req_prot = 3'b101;
    #1 chk("t4_post_req_ready", a_req_ready, 1);
    tick();
    a_req_valid = 1'b0;
    chk("t4_post_arvalid", a_arvalid, 1);
    chk("t4_post_araddr", a_araddr, 32'h40);
    chk("t4_post_arprot", a_arprot, 3'b101);
    a_arready = 1'b1;
    tick();
    a_arready = 1'b0;
    a_rvalid = 1'b1; a_rdata = 32'hC0; a_rresp = 2'b01;
    tick();
    a_rvalid = 1'b0;
    chk("t4_post_rsp_valid", a_rsp_valid, 1);
    chk("t4_post_rsp_data", a_rsp_data, 32'hC0);
    chk("t4_post_rsp_resp", a_rsp_resp, 2'b01);
    chk("t4_post_outstanding", a_outstanding, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
